climate_ctrl: RTL and testbench
===============================

CLIMATE_CTRL -- requirements
Module: climate_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- TEMP_W, 5, temperature width in bits, unsigned.
- HEAT_ON, 18, heating starts at or below this value.
- TARGET, 20, heating/cooling terminates at this value.
- COOL_ON, 22, cooling starts at or above this value.
- MIN_DWELL, 4, minimum cycles in any state before a non-forced exit; range 1..255.
- FAULT_CNT, 3, consecutive out-of-range samples that trip a fault; used only with CLIMATE_FAULT_EN.
- TEMP_MIN, 1, lowest legal temperature; used only with CLIMATE_FAULT_EN.
- TEMP_MAX, 30, highest legal temperature; used only with CLIMATE_FAULT_EN.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  controller enable.
- temp  in  TEMP_W  current temperature sample, read every cycle.
- heating  out  1  heater drive, registered.
- cooling  out  1  cooler drive, registered.
- state  out  2  current FSM state code.
- fault  out  1  sticky fault flag; constant 0 without CLIMATE_FAULT_EN.
REQ-003 Parameters SHALL satisfy HEAT_ON < TARGET < COOL_ON; the simulation model SHALL report an error at time 0 otherwise.

Function
REQ-004 The FSM SHALL have states IDLE=2'b00, HEAT=2'b01, COOL=2'b10, FAULT=2'b11.
REQ-005 heating SHALL be 1 iff state==HEAT; cooling SHALL be 1 iff state==COOL; both SHALL never be 1 together.
REQ-006 From IDLE: temp<=HEAT_ON -> HEAT; else temp>=COOL_ON -> COOL; else stay.
REQ-007 From HEAT: temp>=TARGET -> IDLE; from COOL: temp<=TARGET -> IDLE; HEAT<->COOL direct transitions SHALL NOT occur.
REQ-008 Latency SHALL be one cycle: temp sampled at edge N sets outputs after edge N.
REQ-009 A dwell counter (8 bits) SHALL load MIN_DWELL-1 on every state change and decrement to 0, saturating at 0.
REQ-010 Transitions of REQ-006/REQ-007 SHALL be taken only when the dwell counter is 0; otherwise the state holds.
REQ-011 enable=0 SHALL force IDLE at the next edge regardless of dwell, and clear the dwell counter; FAULT is exempt.
REQ-012 Comparisons SHALL be unsigned at TEMP_W bits; temp=0 and temp=2^TEMP_W-1 SHALL behave as ordinary values.

Reset
REQ-013 rst=1 SHALL immediately, without a clock edge, set state=IDLE, heating=0, cooling=0, fault=0, and clear the dwell and fault counters.
REQ-014 Reset during HEAT, COOL or FAULT SHALL behave identically to REQ-013; the first post-reset decision SHALL occur at the first edge after rst falls, with no dwell blocking.

Configuration
REQ-015 Macro CLIMATE_FAULT_EN, when defined, SHALL include a fault counter incrementing each cycle temp<TEMP_MIN or temp>TEMP_MAX and clearing on any in-range sample.
REQ-016 With CLIMATE_FAULT_EN, counter reaching FAULT_CNT SHALL force FAULT at that edge from any state, ignoring dwell and enable; fault=1 and outputs 0 until rst.
REQ-017 Without CLIMATE_FAULT_EN, no fault logic SHALL exist, FAULT SHALL be unreachable, and fault SHALL be tied to 0.

Structure
REQ-018 Package climate_pkg SHALL hold the state typedef and the four state-code constants.
REQ-019 The dwell counter SHALL be a sub-module dwell_timer (load, count, zero flag), instantiated once.

Verification
REQ-020 Defaults; rst pulse with temp=20 -> state=00, heating=0, cooling=0, fault=0.
REQ-021 temp=17 -> heating=1 after next edge; temp=19 -> heating holds; temp=20 after dwell expiry -> heating=0, state=00.
REQ-022 Enter HEAT at edge t, then temp=25 -> heating=1 through edge t+3, IDLE at edge t+4, COOL at edge t+8.
REQ-023 In HEAT with dwell non-zero, enable=0 -> state=00, heating=0 after the next edge.
REQ-024 With CLIMATE_FAULT_EN: temp=0 for 3 cycles -> state=11, fault=1; temp=20 afterwards -> fault remains 1; rst -> fault=0.
REQ-025 In COOL, assert rst between clock edges -> cooling=0 and state=00 before the next rising edge.

Source files
------------

// File: rtl/climate_pkg.sv
// ============================================================================
// Module  : climate_pkg
// Brief   : State encoding and shared constants for the climate controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package climate_pkg;

    localparam logic [1:0] c_st_idle = 2'b00;
    localparam logic [1:0] c_st_heat = 2'b01;
    localparam logic [1:0] c_st_cool = 2'b10;
    localparam logic [1:0] c_st_fault = 2'b11;

    localparam int c_dwell_w = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = c_st_idle,
        ST_HEAT  = c_st_heat,
        ST_COOL  = c_st_cool,
        ST_FAULT = c_st_fault
    } state_t;

endpackage

`default_nettype wire

// File: rtl/climate_ctrl_dwell_timer.sv
// ============================================================================
// Module  : dwell_timer
// Brief   : Loadable down-counter saturating at zero, with zero flag.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dwell_timer
    import climate_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic [c_dwell_w-1:0] i_load_val,
    output logic                 o_zero
);

    logic [c_dwell_w-1:0] r_count;

    // Clear takes priority over load so a disable never leaves a pending dwell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/climate_ctrl.sv
// ============================================================================
// Module  : climate_ctrl
// Brief   : Hysteresis heat/cool controller with minimum dwell per state.
//           Optional sensor-range fault detection under macro CLIMATE_FAULT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module climate_ctrl
    import climate_pkg::*;
#(
    parameter int TEMP_W    = 5,
    parameter int HEAT_ON   = 18,
    parameter int TARGET    = 20,
    parameter int COOL_ON   = 22,
    parameter int MIN_DWELL = 4,
    parameter int FAULT_CNT = 3,
    parameter int TEMP_MIN  = 1,
    parameter int TEMP_MAX  = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [TEMP_W-1:0] temp,
    output logic              heating,
    output logic              cooling,
    output logic [1:0]        state,
    output logic              fault
);

    localparam logic [TEMP_W-1:0]    c_heat_on    = TEMP_W'(HEAT_ON);
    localparam logic [TEMP_W-1:0]    c_target     = TEMP_W'(TARGET);
    localparam logic [TEMP_W-1:0]    c_cool_on    = TEMP_W'(COOL_ON);
    localparam logic [c_dwell_w-1:0] c_dwell_load = c_dwell_w'(MIN_DWELL - 1);

    generate
        if (!(HEAT_ON < TARGET && TARGET < COOL_ON)) begin : g_bad_thresholds
            $error("climate_ctrl: require HEAT_ON < TARGET < COOL_ON");
        end
        if (MIN_DWELL < 1 || MIN_DWELL > 255) begin : g_bad_dwell
            $error("climate_ctrl: MIN_DWELL must be in 1..255");
        end
        if (FAULT_CNT < 1 || FAULT_CNT > 255 || TEMP_MIN > TEMP_MAX) begin : g_bad_fault
            $error("climate_ctrl: bad FAULT_CNT or TEMP_MIN/TEMP_MAX");
        end
    endgenerate

    state_t r_state;
    state_t w_next;
    logic   r_heating;
    logic   r_cooling;
    logic   r_fault;
    logic   w_dwell_zero;
    logic   w_fault_trip;

`ifdef CLIMATE_FAULT_EN
    logic [7:0] r_fault_cnt;
    logic [7:0] w_fault_cnt_next;
    logic       w_out_of_range;

    assign w_out_of_range   = (temp < TEMP_W'(TEMP_MIN)) || (temp > TEMP_W'(TEMP_MAX));
    assign w_fault_cnt_next = !w_out_of_range ? 8'd0 :
                              (r_fault_cnt == 8'hFF) ? 8'hFF : r_fault_cnt + 8'd1;
    // Trips on the same edge that the run of bad samples reaches FAULT_CNT.
    assign w_fault_trip     = (w_fault_cnt_next >= 8'(FAULT_CNT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault_cnt <= 8'd0;
        end else begin
            r_fault_cnt <= w_fault_cnt_next;
        end
    end
`else
    assign w_fault_trip = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        if (r_state == ST_FAULT) begin
            w_next = ST_FAULT;
        end else if (w_fault_trip) begin
            w_next = ST_FAULT;
        end else if (!enable) begin
            w_next = ST_IDLE;
        end else if (w_dwell_zero) begin
            case (r_state)
                ST_IDLE: begin
                    if (temp <= c_heat_on) begin
                        w_next = ST_HEAT;
                    end else if (temp >= c_cool_on) begin
                        w_next = ST_COOL;
                    end
                end
                ST_HEAT: if (temp >= c_target) w_next = ST_IDLE;
                ST_COOL: if (temp <= c_target) w_next = ST_IDLE;
                default: w_next = r_state;
            endcase
        end
    end

    dwell_timer u_dwell_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (!enable && (r_state != ST_FAULT)),
        .i_load     (w_next != r_state),
        .i_load_val (c_dwell_load),
        .o_zero     (w_dwell_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_heating <= 1'b0;
            r_cooling <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_heating <= (w_next == ST_HEAT);
            r_cooling <= (w_next == ST_COOL);
            r_fault   <= (w_next == ST_FAULT);
        end
    end

    assign state   = r_state;
    assign heating = r_heating;
    assign cooling = r_cooling;
    assign fault   = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_climate_ctrl.sv
// ============================================================================
// Module  : tb_climate_ctrl
// Brief   : Directed and random stimulus against a cycle-age reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_climate_ctrl;

    localparam int TEMP_W    = 5;
    localparam int HEAT_ON   = 18;
    localparam int TARGET    = 20;
    localparam int COOL_ON   = 22;
    localparam int MIN_DWELL = 4;
    localparam int FAULT_CNT = 3;
    localparam int TEMP_MIN  = 1;
    localparam int TEMP_MAX  = 30;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b1;
    logic [TEMP_W-1:0] temp = TEMP_W'(20);
    logic              heating;
    logic              cooling;
    logic [1:0]        state;
    logic              fault;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: state code, edges spent in the current state, bad-sample run.
    int m_state = 0;
    int m_age   = MIN_DWELL;
    int m_run   = 0;

    climate_ctrl #(
        .TEMP_W(TEMP_W), .HEAT_ON(HEAT_ON), .TARGET(TARGET), .COOL_ON(COOL_ON),
        .MIN_DWELL(MIN_DWELL), .FAULT_CNT(FAULT_CNT),
        .TEMP_MIN(TEMP_MIN), .TEMP_MAX(TEMP_MAX)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .temp(temp),
        .heating(heating), .cooling(cooling), .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = 0;
        m_age   = MIN_DWELL;
        m_run   = 0;
    endfunction

    function automatic void model_edge(input logic en, input int t);
        int nxt;
        bit fault_on;
`ifdef CLIMATE_FAULT_EN
        fault_on = 1'b1;
`else
        fault_on = 1'b0;
`endif
        if (m_age < 1000) m_age++;
        if (fault_on) m_run = (t < TEMP_MIN || t > TEMP_MAX) ? m_run + 1 : 0;
        nxt = m_state;
        if (m_state == 3) begin
            nxt = 3;
        end else if (fault_on && m_run >= FAULT_CNT) begin
            nxt = 3;
        end else if (!en) begin
            nxt = 0;
        end else if (m_age >= MIN_DWELL) begin
            if (m_state == 0 && t <= HEAT_ON) nxt = 1;
            else if (m_state == 0 && t >= COOL_ON) nxt = 2;
            else if (m_state == 1 && t >= TARGET) nxt = 0;
            else if (m_state == 2 && t <= TARGET) nxt = 0;
        end
        if (nxt != m_state) m_age = 0;
        if (!en && m_state != 3 && nxt != 3) m_age = MIN_DWELL;
        m_state = nxt;
    endfunction

    task automatic check_model(input string tag);
        check_val({tag, ".state"},   32'(state),   32'(m_state));
        check_val({tag, ".heating"}, 32'(heating), 32'(m_state == 1));
        check_val({tag, ".cooling"}, 32'(cooling), 32'(m_state == 2));
        check_val({tag, ".fault"},   32'(fault),   32'(m_state == 3));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge(enable, int'(temp));
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_model("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // Power-on reset with temp at target.
        temp = TEMP_W'(20);
        do_reset();
        check_val("por.state", 32'(state), 32'd0);

        // Heat entry, hold, and release after dwell.
        temp = TEMP_W'(17);
        step("heat_in");
        check_val("heat_in.heating", 32'(heating), 32'd1);
        temp = TEMP_W'(19);
        for (int i = 0; i < 3; i++) step("heat_hold");
        check_val("heat_hold.heating", 32'(heating), 32'd1);
        temp = TEMP_W'(20);
        step("heat_out");
        check_val("heat_out.state", 32'(state), 32'd0);

        // Dwell timing: HEAT at t, IDLE at t+4, COOL at t+8.
        do_reset();
        temp = TEMP_W'(17);
        step("dw_t");
        temp = TEMP_W'(25);
        for (int i = 1; i <= 3; i++) begin
            step("dw_hold");
            check_val("dw_hold.heating", 32'(heating), 32'd1);
        end
        step("dw_t4");
        check_val("dw_t4.state", 32'(state), 32'd0);
        for (int i = 5; i <= 7; i++) step("dw_idle");
        check_val("dw_t7.state", 32'(state), 32'd0);
        step("dw_t8");
        check_val("dw_t8.state", 32'(state), 32'd2);

        // Disable overrides dwell and clears it.
        do_reset();
        temp = TEMP_W'(17);
        step("en_heat");
        enable = 1'b0;
        step("en_off");
        check_val("en_off.state", 32'(state), 32'd0);
        check_val("en_off.heating", 32'(heating), 32'd0);
        enable = 1'b1;
        step("en_back");
        check_val("en_back.state", 32'(state), 32'd1);

        // Asynchronous reset from COOL between edges.
        do_reset();
        temp = TEMP_W'(25);
        step("ar_cool");
        check_val("ar_cool.cooling", 32'(cooling), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("ar.cooling", 32'(cooling), 32'd0);
        check_val("ar.state", 32'(state), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

`ifdef CLIMATE_FAULT_EN
        // Three out-of-range samples trip the sticky fault.
        temp = TEMP_W'(0);
        for (int i = 0; i < 3; i++) step("flt_run");
        check_val("flt.state", 32'(state), 32'd3);
        check_val("flt.fault", 32'(fault), 32'd1);
        temp = TEMP_W'(20);
        enable = 1'b0;
        step("flt_sticky");
        check_val("flt_sticky.fault", 32'(fault), 32'd1);
        enable = 1'b1;
        do_reset();
        check_val("flt_rst.fault", 32'(fault), 32'd0);
`else
        // Extreme codes are ordinary temperatures.
        temp = TEMP_W'(31);
        step("ext_hi");
        check_val("ext_hi.state", 32'(state), 32'd2);
        do_reset();
        temp = TEMP_W'(0);
        step("ext_lo");
        check_val("ext_lo.state", 32'(state), 32'd1);
`endif

        // Randomised run, biased toward threshold values.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0: t = HEAT_ON;
                1: t = TARGET;
                2: t = COOL_ON;
                3: t = HEAT_ON + 1;
                4: t = COOL_ON - 1;
`ifdef CLIMATE_FAULT_EN
                5: t = TEMP_MIN;
                6: t = TEMP_MAX;
                default: t = $urandom_range(TEMP_MIN, TEMP_MAX);
`else
                5: t = 0;
                6: t = (1 << TEMP_W) - 1;
                default: t = $urandom_range(0, (1 << TEMP_W) - 1);
`endif
            endcase
            temp   = TEMP_W'(t);
            enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            else step("rnd");
            check_val("rnd.exclusive", 32'(heating & cooling), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
